// File: rtl/max_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// max_sequencer_pkg
// Shared types and constants for the running-maximum sequencer.
//   state_t        : controller states (IDLE, SCAN, DONE)
//   DATA_W         : sample width in bits
//   LEN_W_DEFAULT  : default width of the scan length / sample counter
// ---------------------------------------------------------------------------
package max_sequencer_pkg;

    localparam int DATA_W        = 8;
    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/max_sequencer_max.sv
// ---------------------------------------------------------------------------
// MAX
// Shared combinational unsigned 8-bit maximum.
// Ports:
//   x   in  8 : first operand (kept on a tie)
//   y   in  8 : second operand
//   max out 8 : larger of x and y
// ---------------------------------------------------------------------------
module MAX
    import max_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] max
);

    assign max = (x >= y) ? x : y;

endmodule

// File: rtl/max_sequencer.sv
// ---------------------------------------------------------------------------
// max_sequencer
// Finds the maximum of a stream of `len` unsigned bytes using one shared MAX
// comparator, with valid/ready handshakes on both input and result.
// Optional feature macro: MAX_SEQUENCER_ARGMAX_EN adds out_idx, the zero-based
// index of the first occurrence of the maximum.
// Ports:
//   clock      in  1     : rising-edge clock
//   reset_n    in  1     : synchronous active-low reset
//   start      in  1     : begin a scan (honoured only in IDLE)
//   len        in  LEN_W : number of samples, sampled on an accepted start
//   in_valid   in  1     : producer sample valid
//   in_ready   out 1     : sample accepted this cycle (SCAN only)
//   in_data    in  8     : unsigned sample
//   out_valid  out 1     : result valid, held until out_ready
//   out_ready  in  1     : consumer takes the result
//   out_max    out 8     : maximum of the scanned samples
//   out_idx    out LEN_W : index of first maximum (ARGMAX builds only)
//   busy       out 1     : high whenever not IDLE
// ---------------------------------------------------------------------------
module max_sequencer
    import max_sequencer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
`ifdef MAX_SEQUENCER_ARGMAX_EN
    output logic [LEN_W-1:0]  out_idx,
`endif
    output logic              busy
);

    state_t            state_q;
    state_t            next_state;
    logic [LEN_W-1:0]  count_q;
    logic              seen_q;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] cmp_max;
    logic              start_ok;
    logic              xfer;

    MAX u_max (
        .x   (max_q),
        .y   (in_data),
        .max (cmp_max)
    );

    // Handshake qualifiers; both depend only on registered state plus inputs.
    assign start_ok = (state_q == IDLE) && start;
    assign xfer     = (state_q == SCAN) && in_valid;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state and output decode. Handshake outputs come from the state
    // register alone so in_ready has no path from in_valid.
    always_comb begin
        next_state = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (len == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                in_ready = 1'b1;
                // The transfer that takes the counter from 1 to 0 ends the scan.
                if (in_valid && (count_q == LEN_W'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Sample counter and running maximum. The very first sample is loaded
    // directly so an initial register value can never win the compare.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
            seen_q  <= 1'b0;
            max_q   <= '0;
        end else if (start_ok) begin
            count_q <= len;
            seen_q  <= 1'b0;
            max_q   <= '0;
        end else if (xfer) begin
            count_q <= count_q - LEN_W'(1);
            seen_q  <= 1'b1;
            max_q   <= seen_q ? cmp_max : in_data;
        end
    end

    assign out_max = max_q;

`ifdef MAX_SEQUENCER_ARGMAX_EN
    logic [LEN_W-1:0] pos_q;
    logic [LEN_W-1:0] idx_q;

    // Index tracking: pos_q counts transfers; idx_q moves only on a strictly
    // greater sample so ties keep the earliest position.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pos_q <= '0;
            idx_q <= '0;
        end else if (start_ok) begin
            pos_q <= '0;
            idx_q <= '0;
        end else if (xfer) begin
            pos_q <= pos_q + LEN_W'(1);
            if (!seen_q || (in_data > max_q)) begin
                idx_q <= pos_q;
            end
        end
    end

    assign out_idx = idx_q;
`endif

endmodule

// File: tb/tb_max_sequencer.sv
// ---------------------------------------------------------------------------
// tb_max_sequencer
// Self-checking bench for max_sequencer: directed scenarios followed by
// randomised scans, compared against a software maximum / first-index model.
// ---------------------------------------------------------------------------
module tb_max_sequencer;
    import max_sequencer_pkg::*;

    localparam int LW = LEN_W_DEFAULT;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              start     = 1'b0;
    logic [LW-1:0]     len       = '0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_max;
`ifdef MAX_SEQUENCER_ARGMAX_EN
    logic [LW-1:0]     out_idx;
`endif
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] samples[$];

    max_sequencer #(.LEN_W(LW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
`ifdef MAX_SEQUENCER_ARGMAX_EN
        .out_idx   (out_idx),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: plain maximum and first index where it occurs.
    task automatic ref_model(output logic [7:0] m, output int idx);
        m   = 8'd0;
        idx = 0;
        foreach (samples[i]) begin
            if (i == 0 || samples[i] > m) begin
                m   = samples[i];
                idx = i;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] em, input int ei);
        check({tag, "_max"}, 32'(out_max), 32'(em));
`ifdef MAX_SEQUENCER_ARGMAX_EN
        check({tag, "_idx"}, 32'(out_idx), 32'(ei));
`else
        if (ei < 0) $display("[TB] unreachable");
`endif
    endtask

    // One complete scan of `samples`, starting from IDLE.
    task automatic run_scan(input int gap, input int bp, input bit stray_start,
                            input bit start_at_hs, input string tag);
        int         n;
        logic [7:0] em;
        int         ei;
        n = samples.size();
        ref_model(em, ei);
        start = 1'b1;
        len   = LW'(n);
        step();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (n == 0) begin
            check({tag, "_zero_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_zero_ready"}, 32'(in_ready), 32'd0);
        end else begin
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            for (int i = 0; i < n; i++) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    step();
                    check({tag, "_stall_ready"}, 32'(in_ready), 32'd1);
                end
                check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
                in_valid = 1'b1;
                in_data  = samples[i];
                if (stray_start && i == 0) begin
                    start = 1'b1;
                    len   = LW'(7);
                end
                step();
                start    = 1'b0;
                in_valid = 1'b0;
            end
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_done_ready"}, 32'(in_ready), 32'd0);
        end
        check_result(tag, em, ei);
        for (int b = 0; b < bp; b++) begin
            step();
            check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_max"}, 32'(out_max), 32'(em));
        end
        out_ready = 1'b1;
        if (start_at_hs) begin
            start = 1'b1;
            len   = LW'(3);
        end
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hold_max"}, 32'(out_max), 32'(em));
    endtask

    initial begin
        // Reset state.
        reset_n = 1'b0;
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        reset_n = 1'b1;
        step();

        // Reset mid-scan after two samples of five.
        start = 1'b1;
        len   = LW'(5);
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(200 + i);
            step();
        end
        reset_n = 1'b0;
        step();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check_result("abort", 8'd0, 0);
        step();
        samples = '{8'd3, 8'd9, 8'd4};
        run_scan(0, 0, 1'b0, 1'b0, "fresh");

        // Back-to-back samples.
        samples = '{8'd12, 8'd15, 8'd30, 8'd5};
        run_scan(0, 0, 1'b0, 1'b0, "b2b");

        // Producer stalls and consumer backpressure.
        samples = '{8'd20, 8'd27, 8'd25};
        run_scan(2, 3, 1'b0, 1'b0, "stall");

        // Ties.
        samples = '{8'd18, 8'd18, 8'd7};
        run_scan(0, 0, 1'b0, 1'b0, "tie_a");
        samples = '{8'd1, 8'd255, 8'd255};
        run_scan(0, 1, 1'b0, 1'b0, "tie_b");

        // Zero length, with a start that coincides with the result handshake.
        samples.delete();
        run_scan(0, 0, 1'b0, 1'b1, "zero");

        // Stray start during SCAN must not restart or reload the counter.
        samples = '{8'd40, 8'd66};
        run_scan(1, 0, 1'b1, 1'b0, "stray");

        // Randomised scans; half use a narrow value range to provoke ties.
        for (int s = 0; s < 32; s++) begin
            int n;
            bit narrow;
            samples.delete();
            n      = $urandom_range(1, 8);
            narrow = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                samples.push_back(narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)));
            end
            run_scan($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
